// File: rtl/mode_router_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mode_router_pkg
// Description : Shared definitions for the mode router. Holds the mode codes
//               carried on mode_req/cur_mode, the controller state encoding,
//               the silent-note value and a counter width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package mode_router_pkg;

    // Mode codes as presented on the slide switch
    localparam int MODE_FREE  = 0;
    localparam int MODE_PLAY  = 1;
    localparam int MODE_UART  = 2;
    localparam int MODE_LEARN = 3;

    // Mode controller states
    typedef logic [1:0] state_t;
    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_DEBOUNCE = 2'd1;
    localparam logic [1:0] ST_MUTE     = 2'd2;

    // Value of an idle note bus
    localparam int NOTE_SILENT = 0;

    // Bits needed to hold values 0..max_val (at least one bit)
    function automatic int cnt_width(input int max_val);
        int w;
        w = $clog2(max_val + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mode_router_debounce.sv
`default_nettype none
// ============================================================================
// Module      : mode_debounce
// Description : Mode request filter. A new request must hold for
//               STABLE_CYCLES before it is accepted, after which a muted
//               guard interval of MUTE_CYCLES runs before cur_mode updates.
//               Build option: MODE_LOCK_EN (handled by the parent, which
//               drives lock low when the feature is disabled).
// Ports       : clk, rst (async, active-low)
//               lock        - hold off new requests / abort a debounce
//               mode_req    - raw mode switch
//               cur_mode    - accepted mode
//               busy        - high while debouncing or muting
//               mode_change - one-cycle pulse aligned with a cur_mode update
// Revision    : 1.0 - initial release
// ============================================================================
module mode_debounce
    import mode_router_pkg::*;
#(
    parameter int MODE_W        = 2,
    parameter int STABLE_CYCLES = 50000,
    parameter int MUTE_CYCLES   = 100000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              lock,
    input  logic [MODE_W-1:0] mode_req,
    output logic [MODE_W-1:0] cur_mode,
    output logic              busy,
    output logic              mode_change
);

    // One counter serves both the debounce and the mute phases
    localparam int c_CNT_MAX = (STABLE_CYCLES > MUTE_CYCLES) ? STABLE_CYCLES : MUTE_CYCLES;
    localparam int c_CNT_W   = cnt_width(c_CNT_MAX);

    localparam logic [c_CNT_W-1:0] c_CNT_ONE     = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_STABLE_LAST = c_CNT_W'(STABLE_CYCLES);
    localparam logic [c_CNT_W-1:0] c_MUTE_LAST   = c_CNT_W'(MUTE_CYCLES - 1);

    state_t              r_state;
    logic [MODE_W-1:0]   r_pending;
    logic [MODE_W-1:0]   r_cur_mode;
    logic [c_CNT_W-1:0]  r_cnt;
    logic                r_mode_change;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= ST_RUN;
            r_pending     <= '0;
            r_cur_mode    <= MODE_W'(MODE_FREE);
            r_cnt         <= '0;
            r_mode_change <= 1'b0;
        end else begin
            r_mode_change <= 1'b0;
            case (r_state)
                ST_RUN: begin
                    if (!lock && (mode_req != r_cur_mode)) begin
                        r_pending <= mode_req;
                        r_cnt     <= c_CNT_ONE;
                        r_state   <= ST_DEBOUNCE;
                    end
                end
                ST_DEBOUNCE: begin
                    // Any wobble restarts from RUN; RUN re-latches next cycle
                    if (lock || (mode_req != r_pending)) begin
                        r_state <= ST_RUN;
                        r_cnt   <= '0;
                    end else if (r_cnt == c_STABLE_LAST) begin
                        r_state <= ST_MUTE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end
                ST_MUTE: begin
                    // Requests are ignored here; lock does not cut it short
                    if (r_cnt == c_MUTE_LAST) begin
                        r_cur_mode    <= r_pending;
                        r_mode_change <= 1'b1;
                        r_state       <= ST_RUN;
                        r_cnt         <= '0;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end
                default: begin
                    r_state <= ST_RUN;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign cur_mode    = r_cur_mode;
    assign mode_change = r_mode_change;
    assign busy        = (r_state != ST_RUN);

endmodule
`default_nettype wire

// File: rtl/mode_router.sv
`default_nettype none
// ============================================================================
// Module      : mode_router
// Description : Top-level mode controller. Debounces the mode switch, mutes
//               the note buses across a mode change, routes the active note
//               source through one registered mux and scores learn-mode hits.
//               Build option: MODE_LOCK_EN adds the mode_lock input; without
//               it the design behaves as if mode_lock were tied low.
// Ports       : clk, rst (async, active-low)
//               mode_req                          - raw mode switch
//               pin_note/uart_note/db_note        - note sources
//               learn_note                        - expected note in LEARN
//               mode_lock (MODE_LOCK_EN only)     - freeze the current mode
//               cur_mode/mode_en/mode_change/busy - mode status
//               note_out/led_note                 - buzzer/VGA and LED buses
//               hit/score                         - learn-mode scoring
// Revision    : 1.0 - initial release
// ============================================================================
module mode_router
    import mode_router_pkg::*;
#(
    parameter int NOTE_W        = 10,
    parameter int MODE_W        = 2,
    parameter int STABLE_CYCLES = 50000,
    parameter int MUTE_CYCLES   = 100000,
    parameter int SCORE_W       = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [MODE_W-1:0]    mode_req,
    input  logic [NOTE_W-1:0]    pin_note,
    input  logic [NOTE_W-1:0]    uart_note,
    input  logic [NOTE_W-1:0]    db_note,
    input  logic [NOTE_W-1:0]    learn_note,
`ifdef MODE_LOCK_EN
    input  logic                 mode_lock,
`endif
    output logic [MODE_W-1:0]    cur_mode,
    output logic [2**MODE_W-1:0] mode_en,
    output logic                 mode_change,
    output logic                 busy,
    output logic [NOTE_W-1:0]    note_out,
    output logic [NOTE_W-1:0]    led_note,
    output logic                 hit,
    output logic [SCORE_W-1:0]   score
);

    localparam int                 c_EN_W      = 2**MODE_W;
    localparam logic [c_EN_W-1:0]  c_EN_ONE    = c_EN_W'(1);
    localparam logic [NOTE_W-1:0]  c_SILENT    = NOTE_W'(NOTE_SILENT);
    localparam logic [SCORE_W-1:0] c_SCORE_ONE = SCORE_W'(1);
    localparam logic [SCORE_W-1:0] c_SCORE_MAX = '1;

    logic w_lock;
`ifdef MODE_LOCK_EN
    assign w_lock = mode_lock;
`else
    assign w_lock = 1'b0;
`endif

    logic [MODE_W-1:0] w_cur_mode;
    logic              w_busy;
    logic              w_mode_change;

    mode_debounce #(
        .MODE_W        (MODE_W),
        .STABLE_CYCLES (STABLE_CYCLES),
        .MUTE_CYCLES   (MUTE_CYCLES)
    ) u_debounce (
        .clk         (clk),
        .rst         (rst),
        .lock        (w_lock),
        .mode_req    (mode_req),
        .cur_mode    (w_cur_mode),
        .busy        (w_busy),
        .mode_change (w_mode_change)
    );

    logic [NOTE_W-1:0]  r_note_out;
    logic [NOTE_W-1:0]  r_led_note;
    logic               r_hit;
    logic [SCORE_W-1:0] r_score;
    logic               r_match_prev;
    logic [NOTE_W-1:0]  r_learn_prev;
    logic               r_led_off;

    logic               w_in_learn;
    logic               w_match;
    logic               w_rise;
    logic               w_learn_chg;
    logic               w_led_blank;
    logic               w_enter_learn;
    logic [NOTE_W-1:0]  w_note_nxt;
    logic [NOTE_W-1:0]  w_led_nxt;

    assign w_in_learn  = !w_busy && (w_cur_mode == MODE_W'(MODE_LEARN));
    assign w_match     = w_in_learn && (pin_note != c_SILENT) && (pin_note == learn_note);
    // Only the press edge scores, so a held key counts once
    assign w_rise      = w_match && !r_match_prev;
    assign w_learn_chg = (learn_note != r_learn_prev);
    // Guide LED goes dark from the hit until the song moves to a new note
    assign w_led_blank = w_rise || (r_led_off && !w_learn_chg);
    assign w_enter_learn = w_mode_change && (w_cur_mode == MODE_W'(MODE_LEARN));

    always_comb begin
        w_note_nxt = c_SILENT;
        w_led_nxt  = c_SILENT;
        if (!w_busy) begin
            case (w_cur_mode)
                MODE_W'(MODE_PLAY): begin
                    w_note_nxt = db_note;
                    w_led_nxt  = db_note;
                end
                MODE_W'(MODE_UART): begin
                    w_note_nxt = uart_note;
                    w_led_nxt  = uart_note;
                end
                MODE_W'(MODE_LEARN): begin
                    w_note_nxt = pin_note;
                    w_led_nxt  = w_led_blank ? c_SILENT : learn_note;
                end
                default: begin
                    // FREE and any unused codes play the keys directly
                    w_note_nxt = pin_note;
                    w_led_nxt  = pin_note;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_note_out   <= c_SILENT;
            r_led_note   <= c_SILENT;
            r_hit        <= 1'b0;
            r_score      <= '0;
            r_match_prev <= 1'b0;
            r_learn_prev <= c_SILENT;
            r_led_off    <= 1'b0;
        end else begin
            r_note_out   <= w_note_nxt;
            r_led_note   <= w_led_nxt;
            r_hit        <= w_rise;
            r_match_prev <= w_match;
            r_learn_prev <= learn_note;

            if (w_rise) begin
                r_led_off <= 1'b1;
            end else if (w_learn_chg) begin
                r_led_off <= 1'b0;
            end

            // Entering LEARN starts a fresh score; a press landing in the
            // same cycle still counts as the first hit
            if (w_enter_learn) begin
                r_score <= w_rise ? c_SCORE_ONE : '0;
            end else if (w_rise && (r_score != c_SCORE_MAX)) begin
                r_score <= r_score + c_SCORE_ONE;
            end
        end
    end

    assign cur_mode    = w_cur_mode;
    assign mode_en     = c_EN_ONE << w_cur_mode;
    assign mode_change = w_mode_change;
    assign busy        = w_busy;
    assign note_out    = r_note_out;
    assign led_note    = r_led_note;
    assign hit         = r_hit;
    assign score       = r_score;

endmodule
`default_nettype wire

// File: tb/tb_mode_router.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_mode_router
// Description : Self-checking bench for mode_router with STABLE_CYCLES=4,
//               MUTE_CYCLES=3. A behavioural model tracks the expected
//               outputs from elapsed-cycle arithmetic; a compare process
//               checks every cycle, and directed scenarios pin literal values.
//               Build option: MODE_LOCK_EN enables the lock scenario.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mode_router;

    localparam int NOTE_W  = 10;
    localparam int MODE_W  = 2;
    localparam int STABLE  = 4;
    localparam int MUTE    = 3;
    localparam int SCORE_W = 8;
    localparam int SMAX    = 255;

    logic              clk        = 1'b0;
    logic              rst        = 1'b0;
    logic [MODE_W-1:0] mode_req   = '0;
    logic [NOTE_W-1:0] pin_note   = '0;
    logic [NOTE_W-1:0] uart_note  = '0;
    logic [NOTE_W-1:0] db_note    = '0;
    logic [NOTE_W-1:0] learn_note = '0;
    logic              mode_lock  = 1'b0;

    logic [MODE_W-1:0]    cur_mode;
    logic [2**MODE_W-1:0] mode_en;
    logic                 mode_change;
    logic                 busy;
    logic [NOTE_W-1:0]    note_out;
    logic [NOTE_W-1:0]    led_note;
    logic                 hit;
    logic [SCORE_W-1:0]   score;

    always #5 clk = ~clk;

    mode_router #(
        .NOTE_W        (NOTE_W),
        .MODE_W        (MODE_W),
        .STABLE_CYCLES (STABLE),
        .MUTE_CYCLES   (MUTE),
        .SCORE_W       (SCORE_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .mode_req    (mode_req),
        .pin_note    (pin_note),
        .uart_note   (uart_note),
        .db_note     (db_note),
        .learn_note  (learn_note),
`ifdef MODE_LOCK_EN
        .mode_lock   (mode_lock),
`endif
        .cur_mode    (cur_mode),
        .mode_en     (mode_en),
        .mode_change (mode_change),
        .busy        (busy),
        .note_out    (note_out),
        .led_note    (led_note),
        .hit         (hit),
        .score       (score)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // ------------------------------------------------------------------
    // Behavioural model: phase 0 idle, 1 filtering, 2 muted. Phase length
    // comes from the cycle number at which the phase began.
    // ------------------------------------------------------------------
    int                m_cyc   = 0;
    int                m_phase = 0;
    int                m_t0    = 0;
    int                m_cur   = 0;
    int                m_pend  = 0;
    logic              m_prev_match = 1'b0;
    logic [NOTE_W-1:0] m_prev_learn = '0;
    logic              m_off   = 1'b0;
    logic [NOTE_W-1:0] e_note  = '0;
    logic [NOTE_W-1:0] e_led   = '0;
    logic              e_hit   = 1'b0;
    logic              e_mc    = 1'b0;
    int                e_score = 0;
    logic              t_idle, t_match, t_rise, t_chg;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_cyc = 0; m_phase = 0; m_t0 = 0; m_cur = 0; m_pend = 0;
            m_prev_match = 1'b0; m_prev_learn = '0; m_off = 1'b0;
            e_note = '0; e_led = '0; e_hit = 1'b0; e_mc = 1'b0; e_score = 0;
        end else begin
            t_idle  = (m_phase == 0);
            t_chg   = (learn_note != m_prev_learn);
            t_match = t_idle && (m_cur == 3) && (pin_note != 0) && (pin_note == learn_note);
            t_rise  = t_match && !m_prev_match;

            if (!t_idle) begin
                e_note = '0;
                e_led  = '0;
            end else if (m_cur == 1) begin
                e_note = db_note;   e_led = db_note;
            end else if (m_cur == 2) begin
                e_note = uart_note; e_led = uart_note;
            end else if (m_cur == 3) begin
                e_note = pin_note;
                e_led  = (t_rise || (m_off && !t_chg)) ? '0 : learn_note;
            end else begin
                e_note = pin_note;  e_led = pin_note;
            end

            if (e_mc && (m_cur == 3))
                e_score = t_rise ? 1 : 0;
            else if (t_rise)
                e_score = (e_score < SMAX) ? e_score + 1 : SMAX;

            e_hit = t_rise;
            if (t_rise)     m_off = 1'b1;
            else if (t_chg) m_off = 1'b0;
            m_prev_match = t_match;
            m_prev_learn = learn_note;

            e_mc  = 1'b0;
            m_cyc = m_cyc + 1;
            if (m_phase == 0) begin
                if (!mode_lock && (int'(mode_req) != m_cur)) begin
                    m_phase = 1; m_pend = int'(mode_req); m_t0 = m_cyc;
                end
            end else if (m_phase == 1) begin
                if (mode_lock || (int'(mode_req) != m_pend))
                    m_phase = 0;
                else if (m_cyc - m_t0 == STABLE) begin
                    m_phase = 2; m_t0 = m_cyc;
                end
            end else begin
                if (m_cyc - m_t0 == MUTE) begin
                    m_cur = m_pend; e_mc = 1'b1; m_phase = 0;
                end
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    logic [3:0] exp_en;
    always @(negedge clk) begin
        exp_en = 4'b0001 << m_cur;
        n_cmp++;
        if (cur_mode !== m_cur[1:0] || mode_en !== exp_en || mode_change !== e_mc ||
            busy !== (m_phase != 0) || note_out !== e_note || led_note !== e_led ||
            hit !== e_hit || score !== e_score[7:0]) begin
            n_bad++;
            $display("FAIL model_cycle t=%0t dut: cur=%0d en=%b mc=%b busy=%b note=%h led=%h hit=%b score=%0d | expected: cur=%0d en=%b mc=%b busy=%b note=%h led=%h hit=%b score=%0d",
                     $time, cur_mode, mode_en, mode_change, busy, note_out, led_note, hit, score,
                     m_cur, exp_en, e_mc, (m_phase != 0), e_note, e_led, e_hit, e_score);
        end
    end

    // Event counters for pulse-count checks (single writer each)
    int hit_cnt = 0;
    int mc_cnt  = 0;
    always @(negedge clk) begin
        if (hit === 1'b1)         hit_cnt++;
        if (mode_change === 1'b1) mc_cnt++;
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Advance n clocks; return 2 ns after the last rising edge
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Wait (bounded) for a mode_change pulse, then align past the next edge
    task automatic wait_mc(input string name, input int max_cycles);
        int  i;
        bit  seen;
        i = 0;
        seen = 1'b0;
        while (!seen && i < max_cycles) begin
            @(negedge clk);
            if (mode_change === 1'b1) seen = 1'b1;
            i++;
        end
        check(name, int'(seen), 1);
        step(1);
    endtask

    function automatic logic [NOTE_W-1:0] pick_note();
        logic [6:0] oh;
        logic [2:0] pitch;
        oh    = 7'(1 << $urandom_range(0, 6));
        pitch = 3'($urandom_range(0, 7));
        return {pitch, oh};
    endfunction

    int base;
    int bad_cnt;

    initial begin
        // ---------------- reset ----------------
        step(3);
        check("reset_cur_mode", int'(cur_mode), 0);
        check("reset_mode_en", int'(mode_en), 1);
        check("reset_busy", int'(busy), 0);
        check("reset_note_out", int'(note_out), 0);
        check("reset_score", int'(score), 0);
        rst = 1'b1;

        // ---------------- FREE: keys pass through ----------------
        for (int i = 0; i < 8; i++) begin
            pin_note = pick_note();
            step(1);
        end
        pin_note = 10'h045;
        step(2);
        check("free_note_out", int'(note_out), 'h045);
        check("free_led_note", int'(led_note), 'h045);

        // ---------------- switch to PLAY ----------------
        pin_note = '0;
        db_note  = 10'h004;
        mode_req = 2'd1;
        step(1);
        check("play_busy_rise", int'(busy), 1);
        step(1);
        check("play_note_muted", int'(note_out), 0);
        wait_mc("play_mode_change", 20);
        check("play_cur_mode", int'(cur_mode), 1);
        check("play_mode_en", int'(mode_en), 'b0010);
        check("play_note_out", int'(note_out), 'h004);

        // ---------------- back to FREE, then glitch ----------------
        mode_req = 2'd0;
        wait_mc("free_mode_change", 20);
        base = mc_cnt;
        mode_req = 2'd2;
        step(3);
        check("glitch_busy_high", int'(busy), 1);
        mode_req = 2'd0;
        step(1);
        check("glitch_busy_fall", int'(busy), 0);
        step(15);
        check("glitch_no_change", mc_cnt - base, 0);
        check("glitch_cur_mode", int'(cur_mode), 0);

        // ---------------- LEARN ----------------
        learn_note = 10'h010;
        mode_req   = 2'd3;
        wait_mc("learn_mode_change", 20);
        check("learn_score_clear", int'(score), 0);
        check("learn_led_guide", int'(led_note), 'h010);
        base = hit_cnt;
        pin_note = 10'h010; step(5);
        pin_note = '0;      step(3);
        pin_note = 10'h010; step(3);
        pin_note = '0;      step(2);
        check("learn_hits", hit_cnt - base, 2);
        check("learn_score", int'(score), 2);
        check("learn_led_dark", int'(led_note), 0);
        learn_note = 10'h020;
        step(2);
        check("learn_led_new", int'(led_note), 'h020);

        // ---------------- score saturation ----------------
        for (int i = 0; i < 253; i++) begin
            pin_note = 10'h020; step(1);
            pin_note = '0;      step(1);
        end
        check("sat_score_255", int'(score), 255);
        base = hit_cnt;
        pin_note = 10'h020; step(1);
        pin_note = '0;      step(1);
        check("sat_hit_pulse", hit_cnt - base, 1);
        check("sat_score_hold", int'(score), 255);

        // ---------------- reset during MUTE ----------------
        mode_req = 2'd1;
        step(1);
        check("mute_busy", int'(busy), 1);
        step(5);
        base = mc_cnt;
        rst = 1'b0;
        mode_req = 2'd0;
        #1;
        check("rstmute_cur_mode", int'(cur_mode), 0);
        check("rstmute_busy", int'(busy), 0);
        check("rstmute_note", int'(note_out), 0);
        check("rstmute_led", int'(led_note), 0);
        check("rstmute_score", int'(score), 0);
        check("rstmute_mc", int'(mode_change), 0);
        step(2);
        rst = 1'b1;
        step(10);
        check("rstmute_no_change", mc_cnt - base, 0);
        check("rstmute_cur_after", int'(cur_mode), 0);

`ifdef MODE_LOCK_EN
        // ---------------- mode lock ----------------
        mode_lock = 1'b1;
        mode_req  = 2'd3;
        bad_cnt   = 0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (busy !== 1'b0 || cur_mode !== 2'd0) bad_cnt++;
        end
        check("lock_hold", bad_cnt, 0);
        mode_lock = 1'b0;
        wait_mc("lock_release_change", 20);
        check("lock_release_mode", int'(cur_mode), 3);
`endif

        // ---------------- randomized traffic ----------------
        learn_note = pick_note();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 39) == 0) mode_req = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 29) == 0) learn_note = pick_note();
            case ($urandom_range(0, 3))
                0: pin_note = '0;
                1: pin_note = learn_note;
                2: pin_note = pick_note();
                default: ;
            endcase
            db_note   = pick_note();
            uart_note = pick_note();
`ifdef MODE_LOCK_EN
            if ($urandom_range(0, 63) == 0) mode_lock = ~mode_lock;
`endif
            step(1);
        end

        step(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
